// File: rtl/tx_pkg.sv
// tx_pkg: shared types and constants for the transmit scheduler.
//   tx_state_t  - scheduler FSM states
//   EOP_BIT, VALID_BIT, BYTE_MSB - fields of the 16-bit transmit word
//   ABORT_CNT_W - width of the saturating abort counter
//   LOW_CYCLES  - cycles tx_strobe is held low after every strobe
//   sat_inc()   - saturating increment for the abort counter
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_WAIT_REQ,
    ST_STROBE,
    ST_LOW,
    ST_IFG,
    ST_ABORT
  } tx_state_t;

  localparam int EOP_BIT     = 15;
  localparam int VALID_BIT   = 14;
  localparam int BYTE_MSB    = 7;
  localparam int ABORT_CNT_W = 8;
  localparam int LOW_CYCLES  = 2;

  function automatic logic [ABORT_CNT_W-1:0] sat_inc(input logic [ABORT_CNT_W-1:0] v);
    return (v == {ABORT_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tx_rr_arb.sv
// tx_rr_arb: combinational winner pick among frame sources.
//   req    in  NREQ   pending requests
//   ptr    in  PTR_W  round-robin start index
//   winner out NREQ   one-hot winner, all zero when nothing is requested
// Build option TX_SCHED_PRIO_EN: fixed priority (lowest index wins), ptr ignored.
module tx_rr_arb
  import tx_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner
);

`ifdef TX_SCHED_PRIO_EN
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`else
  // Scan starting at ptr and wrapping, so the source after the last
  // winner gets first chance.
  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/tx_sched.sv
// tx_sched: grants one frame source at a time and feeds its words to tx_top.
//   clk, reset_n  clock and asynchronous active-low reset
//   src_req/src_data/src_valid/src_pop  per-source frame word interface
//   grant         one-hot owner of the transmitter
//   tx_go         one-cycle start pulse to tx_top
//   tx_word/tx_strobe  word and strobe to tx_top, tx_request back
//   tx_underrun/tx_overrun  error flags from tx_top
//   busy          scheduler not idle
//   abort_cnt     saturating count of aborted frames
// Build option TX_SCHED_PRIO_EN selects fixed-priority arbitration.
module tx_sched
  import tx_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int IFG_CYCLES     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        src_req,
  input  logic [16*NREQ-1:0]     src_data,
  input  logic [NREQ-1:0]        src_valid,
  output logic [NREQ-1:0]        src_pop,
  output logic [NREQ-1:0]        grant,
  output logic                   tx_go,
  output logic [15:0]            tx_word,
  output logic                   tx_strobe,
  input  logic                   tx_request,
  input  logic                   tx_underrun,
  input  logic                   tx_overrun,
  output logic                   busy,
  output logic [ABORT_CNT_W-1:0] abort_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  tx_state_t        state;
  logic [PTR_W-1:0] ptr;
  logic [31:0]      cnt;
  logic             err_pend;
  logic             underrun_q;
  logic [NREQ-1:0]  winner;
  logic [15:0]      cur_data;
  logic             cur_valid;
  logic             cur_req;
  logic [PTR_W-1:0] g_idx;
  logic             in_frame;
  logic             err_now;
  logic             err_hit;
  logic             accept;
  logic             abort_done;

  tx_rr_arb #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req    (src_req),
    .ptr    (ptr),
    .winner (winner)
  );

  // Route the granted source's word interface to a single set of signals.
  always_comb begin
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_req   = 1'b0;
    g_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        cur_data  = src_data[16*i +: 16];
        cur_valid = src_valid[i];
        cur_req   = src_req[i];
        g_idx     = PTR_W'(i);
      end
    end
  end

  assign in_frame = (state == ST_WAIT_REQ) || (state == ST_STROBE) || (state == ST_LOW);
  assign err_now  = (tx_underrun & ~underrun_q) | tx_overrun;
  assign err_hit  = err_pend | err_now;
  assign accept   = (state == ST_WAIT_REQ) && !err_hit && tx_request && cur_valid;
  assign abort_done = (cur_valid && cur_data[EOP_BIT]) || !cur_req ||
                      (cnt == 32'(TIMEOUT_CYCLES - 1));

  // Pop is combinational so the source sees it in the cycle its word is taken.
  always_comb begin
    src_pop = '0;
    if (accept) src_pop = grant;
    if (state == ST_ABORT && cur_valid) src_pop = grant;
  end

  // Scheduler FSM. cnt is shared by the timeout, LOW and IFG phases and is
  // cleared on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      err_pend   <= 1'b0;
      underrun_q <= 1'b0;
      grant      <= '0;
      tx_go      <= 1'b0;
      tx_word    <= '0;
      tx_strobe  <= 1'b0;
      busy       <= 1'b0;
      abort_cnt  <= '0;
    end else begin
      underrun_q <= tx_underrun;
      tx_go      <= 1'b0;
      tx_strobe  <= 1'b0;
      // An error seen mid-word is remembered until the LOW phase finishes.
      if (in_frame && err_now) err_pend <= 1'b1;
      else if (!in_frame)      err_pend <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (|src_req) begin
            grant <= winner;
            tx_go <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= ST_GO;
          end
        end
        ST_GO: begin
          cnt   <= '0;
          state <= ST_WAIT_REQ;
        end
        ST_WAIT_REQ: begin
          if (err_hit || (!accept && cnt == 32'(TIMEOUT_CYCLES - 1))) begin
            abort_cnt <= sat_inc(abort_cnt);
            cnt       <= '0;
            state     <= ST_ABORT;
          end else if (accept) begin
            tx_word   <= cur_data;
            tx_strobe <= 1'b1;
            cnt       <= '0;
            state     <= ST_STROBE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_STROBE: begin
          cnt   <= '0;
          state <= ST_LOW;
        end
        ST_LOW: begin
          if (cnt == 32'(LOW_CYCLES - 1)) begin
            cnt <= '0;
            // A frame whose eop word already went out has nothing left to
            // flush, so an error there must not eat the next frame's words.
            if (tx_word[EOP_BIT]) begin
              state <= ST_IFG;
            end else if (err_hit) begin
              abort_cnt <= sat_inc(abort_cnt);
              state     <= ST_ABORT;
            end else begin
              state <= ST_WAIT_REQ;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_IFG: begin
          if (cnt == 32'(IFG_CYCLES - 1)) begin
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= (int'(g_idx) == NREQ - 1) ? '0 : g_idx + 1'b1;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_ABORT: begin
          // The timeout also bounds the flush so a silent source cannot
          // hold the transmitter forever.
          if (abort_done) begin
            cnt   <= '0;
            state <= ST_IFG;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: randomized self-checking bench for tx_sched.
// Sources are modelled as word queues; every grant, strobe and pop is
// checked against a queue-level reference of the arbitration and framing rules.
// Honours TX_SCHED_PRIO_EN when the design is built with it.
module tb_tx_sched;

  localparam int NREQ = 2;
  localparam int IFG  = 8;
  localparam int TMO  = 40;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   src_req;
  logic [16*NREQ-1:0] src_data;
  logic [NREQ-1:0]   src_valid;
  logic [NREQ-1:0]   src_pop;
  logic [NREQ-1:0]   grant;
  logic              tx_go;
  logic [15:0]       tx_word;
  logic              tx_strobe;
  logic              tx_request;
  logic              tx_underrun;
  logic              tx_overrun;
  logic              busy;
  logic [7:0]        abort_cnt;

  always #5 clk = ~clk;

  tx_sched #(.NREQ(NREQ), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_req     (src_req),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_pop     (src_pop),
    .grant       (grant),
    .tx_go       (tx_go),
    .tx_word     (tx_word),
    .tx_strobe   (tx_strobe),
    .tx_request  (tx_request),
    .tx_underrun (tx_underrun),
    .tx_overrun  (tx_overrun),
    .busy        (busy),
    .abort_cnt   (abort_cnt)
  );

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  bit   valid_rand = 1'b0;
  bit   req_rand   = 1'b0;
  bit   req_level  = 1'b1;
  bit   underrun_drv = 1'b0;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   go_cnt   = 0;
  int   strobe_cnt = 0;
  int   pop_cnt  = 0;
  int   last_strobe_cyc = -100;
  int   go_cyc   = 0;
  int   abort_lat = -1;
  int   grant_fall_gap = -1;
  int   model_ptr = 0;
  logic prev_go = 1'b0;
  logic [7:0] prev_abort = 8'd0;
  logic [NREQ-1:0] prev_grant = '0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference arbitration: first pending source at or after the pointer,
  // or the lowest pending index in fixed-priority builds.
  function automatic int pick(input bit r0, input bit r1, input int p);
    bit r[2];
    r[0] = r0;
    r[1] = r1;
`ifdef TX_SCHED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic monitor();
    int   e;
    logic nonempty;
    if (tx_go) begin
      go_cnt++;
      go_cyc = cyc;
      check_output("go_single_cycle", prev_go, 0);
      e = pick(q0.size() != 0, q1.size() != 0, model_ptr);
      check_output("grant_winner", grant, (e < 0) ? 0 : (1 << e));
      if (e >= 0) model_ptr = (e + 1) % NREQ;
    end
    prev_go = tx_go;
    if (tx_strobe) begin
      strobe_cnt++;
      check_output("strobe_gap", (cyc - last_strobe_cyc) >= 3, 1);
      last_strobe_cyc = cyc;
      nonempty = (grant == 2'b01) ? (exp0.size() != 0) : (exp1.size() != 0);
      check_output("strobe_expected", nonempty, 1);
      if (nonempty) begin
        if (grant == 2'b01) check_output("tx_word", tx_word, exp0.pop_front());
        else                check_output("tx_word", tx_word, exp1.pop_front());
      end
    end
    if (src_pop != '0) begin
      check_output("pop_granted", src_pop & ~grant, 0);
      if (src_pop[0]) begin
        pop_cnt++;
        check_output("pop_nonempty0", q0.size() != 0, 1);
        if (q0.size() != 0) void'(q0.pop_front());
      end
      if (src_pop[1]) begin
        pop_cnt++;
        check_output("pop_nonempty1", q1.size() != 0, 1);
        if (q1.size() != 0) void'(q1.pop_front());
      end
    end
    if (abort_cnt != prev_abort) abort_lat = cyc - go_cyc;
    prev_abort = abort_cnt;
    if (prev_grant != '0 && grant == '0) grant_fall_gap = cyc - last_strobe_cyc - 1;
    prev_grant = grant;
  endtask

  // One clock: drive inputs just after the rising edge, observe at the falling edge.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    src_req   = {q1.size() != 0, q0.size() != 0};
    src_valid[0] = (q0.size() != 0) && (!valid_rand || ($urandom_range(0, 3) != 0));
    src_valid[1] = (q1.size() != 0) && (!valid_rand || ($urandom_range(0, 3) != 0));
    src_data = '0;
    if (q0.size() != 0) src_data[15:0]  = q0[0];
    if (q1.size() != 0) src_data[31:16] = q1[0];
    tx_request  = req_rand ? ($urandom_range(0, 1) == 1) : req_level;
    tx_underrun = underrun_drv;
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (!(busy == 1'b0 && q0.size() == 0 && q1.size() == 0) && n < max_cyc) begin
      apply_stimulus();
      n++;
    end
    check_output({tag, "_done"}, n < max_cyc, 1);
  endtask

  function automatic logic [15:0] rand_word(input bit eop);
    logic [15:0] w;
    w = 16'($urandom);
    w[15] = eop;
    w[14] = 1'b1;
    return w;
  endfunction

  initial begin
    int go0, s0, p0, n, len;
    logic [7:0] a0;
    logic [15:0] w;

    reset_n = 1'b0;
    src_req = '0; src_valid = '0; src_data = '0;
    tx_request = 1'b0; tx_underrun = 1'b0; tx_overrun = 1'b0;
    repeat (3) apply_stimulus();
    check_output("rst_grant", grant, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_go", tx_go, 0);
    check_output("rst_strobe", tx_strobe, 0);
    check_output("rst_abort_cnt", abort_cnt, 0);
    check_output("rst_tx_word", tx_word, 0);
    check_output("rst_src_pop", src_pop, 0);
    reset_n = 1'b1;
    apply_stimulus();

    // Single three-word frame from source 0.
    valid_rand = 1'b1; req_rand = 1'b0; req_level = 1'b1;
    q0 = '{16'h4011, 16'h4022, 16'hC033};
    exp0 = q0;
    go0 = go_cnt; s0 = strobe_cnt;
    wait_done("t1", 500);
    check_output("t1_go_count", go_cnt - go0, 1);
    check_output("t1_strobe_count", strobe_cnt - s0, 3);
    check_output("t1_all_sent", exp0.size(), 0);
    check_output("t1_ifg_grant_hold", grant_fall_gap, 2 + IFG);
    check_output("t1_grant_idle", grant, 0);

    // Both sources, three random frames each, random tx_request.
    req_rand = 1'b1;
    for (int f = 0; f < 3; f++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        w = rand_word(k == len - 1);
        q0.push_back(w); exp0.push_back(w);
      end
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        w = rand_word(k == len - 1);
        q1.push_back(w); exp1.push_back(w);
      end
    end
    go0 = go_cnt; a0 = abort_cnt;
    wait_done("t2", 3000);
    check_output("t2_go_count", go_cnt - go0, 6);
    check_output("t2_all_sent0", exp0.size(), 0);
    check_output("t2_all_sent1", exp1.size(), 0);
    check_output("t2_no_abort", abort_cnt, a0);

    // tx_request held low: timeout, flush to eop, then idle.
    req_rand = 1'b0; req_level = 1'b0; valid_rand = 1'b0;
    q0 = '{16'h4001, 16'h4002, 16'hC003};
    s0 = strobe_cnt; p0 = pop_cnt; a0 = abort_cnt;
    wait_done("t3", 500);
    check_output("t3_abort_cnt", abort_cnt, a0 + 8'd1);
    check_output("t3_timeout_latency", abort_lat, TMO + 1);
    check_output("t3_no_strobe", strobe_cnt - s0, 0);
    check_output("t3_flush_pops", pop_cnt - p0, 3);
    check_output("t3_idle_busy", busy, 0);

    // Underrun after the second word of a five-word frame.
    req_level = 1'b1;
    q0 = '{16'h4051, 16'h4052, 16'h4053, 16'h4054, 16'hC055, 16'h4061, 16'hC062};
    exp0 = '{16'h4051, 16'h4052, 16'h4061, 16'hC062};
    s0 = strobe_cnt; p0 = pop_cnt; a0 = abort_cnt; go0 = go_cnt;
    n = 0;
    while (strobe_cnt - s0 < 2 && n < 300) begin apply_stimulus(); n++; end
    check_output("t4_reached_word2", n < 300, 1);
    underrun_drv = 1'b1;
    apply_stimulus();
    underrun_drv = 1'b0;
    wait_done("t4", 800);
    check_output("t4_abort_cnt", abort_cnt, a0 + 8'd1);
    check_output("t4_strobe_count", strobe_cnt - s0, 4);
    check_output("t4_all_sent", exp0.size(), 0);
    check_output("t4_pop_count", pop_cnt - p0, 7);
    check_output("t4_go_count", go_cnt - go0, 2);

    // Reset asserted while tx_strobe is high.
    q0 = '{16'h4071, 16'h4072, 16'hC073};
    exp0 = q0;
    s0 = strobe_cnt; n = 0;
    while (strobe_cnt == s0 && n < 300) begin apply_stimulus(); n++; end
    check_output("t5_reached_strobe", n < 300, 1);
    reset_n = 1'b0;
    #1;
    check_output("t5_async_strobe", tx_strobe, 0);
    check_output("t5_async_grant", grant, 0);
    check_output("t5_async_busy", busy, 0);
    check_output("t5_async_abort_cnt", abort_cnt, 0);
    q0.delete(); exp0.delete();
    model_ptr = 0;
    repeat (2) apply_stimulus();
    reset_n = 1'b1;
    q0 = '{16'hC081};
    exp0 = q0;
    go0 = go_cnt;
    wait_done("t5", 500);
    check_output("t5_go_after_reset", go_cnt - go0, 1);
    check_output("t5_all_sent", exp0.size(), 0);

    // 260 timed-out single-word frames saturate abort_cnt.
    req_level = 1'b0;
    for (int f = 0; f < 260; f++) q0.push_back({8'hC0, 8'(f)});
    s0 = strobe_cnt;
    wait_done("t6", 20000);
    check_output("t6_abort_saturated", abort_cnt, 8'd255);
    check_output("t6_no_strobe", strobe_cnt - s0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_sched.md
Name: tx_sched

Overview:
- Arbitrates between NREQ frame sources and sequences the transmit datapath (tx_top) on the same clk.
- Grants one source per frame. Issues go, then moves its 16-bit words into tx_top's strobe/request word interface. Word format: bit15 = eop, bit14 = byte valid, bits7:0 = byte.
- Enforces an inter-frame gap, detects stalls and underrun, and flushes an aborted frame so the next source starts clean.

Parameters:
- NREQ, 2, number of frame sources (2..8).
- IFG_CYCLES, 32, idle clk cycles after a frame before the next grant.
- TIMEOUT_CYCLES, 4096, maximum clk cycles spent waiting for tx_request or src_valid before the frame is aborted.

Ports:
- clk  in  1  system clock, same domain as tx_top clk.
- reset_n  in  1  asynchronous active-low reset.
- src_req  in  NREQ  source i has a frame pending; level signal.
- src_data  in  16*NREQ  word of source i at bits [16i+15:16i].
- src_valid  in  NREQ  word of source i valid.
- src_pop  out  NREQ  one-cycle pulse: word of source i consumed.
- grant  out  NREQ  one-hot; the source owning the transmitter.
- tx_go  out  1  one-cycle go pulse to tx_top.
- tx_word  out  16  word to tx_top spi_data.
- tx_strobe  out  1  word strobe to tx_top; tx_top samples on its rising edge.
- tx_request  in  1  tx_top spi_data_request.
- tx_underrun  in  1  framer underrun flag.
- tx_overrun  in  1  tx_top overrun flag (sticky in tx_top).
- busy  out  1  not IDLE.
- abort_cnt  out  8  saturating count of aborted frames.

Behaviour:
- Reset values: all outputs 0. State = IDLE; round-robin pointer = 0; gap counter = 0.
- States:
  - IDLE: if any src_req, select a winner by round-robin starting at the pointer. Assert grant one-hot next cycle; go to GO.
  - GO: tx_go = 1 for exactly one cycle. Then WAIT_REQ.
  - WAIT_REQ: wait for tx_request = 1 and src_valid[g] = 1.
    - tx_word <= src_data[g]; src_pop[g] pulses in the same cycle; go to STROBE.
    - If the timeout counter reaches TIMEOUT_CYCLES, go to ABORT.
  - STROBE: tx_strobe = 1 for exactly 1 cycle. tx_word is held stable. Then LOW.
  - LOW: tx_strobe = 0 for at least 2 cycles, so tx_top sees the edge and updates request.
    - If the sent word had eop = 1, go to IFG.
    - Otherwise go to WAIT_REQ.
  - IFG: count IFG_CYCLES cycles with grant held. Then drop grant, advance the pointer to g+1 (mod NREQ), and return to IDLE.
  - ABORT: increment abort_cnt (saturates at 255). Pop src[g] words, one per cycle while src_valid, until a popped word has eop = 1 or src_req[g] drops. Never strobe during ABORT. Then IFG.
- tx_word changes only in the WAIT_REQ→STROBE transition. tx_strobe is never high in two consecutive cycles.
- Rising edge of tx_underrun, or tx_overrun = 1, while in WAIT_REQ/STROBE/LOW: go to ABORT after the current LOW completes.
- tx_request falling while the current word has eop = 0: no error. Wait in WAIT_REQ; the timeout applies.
- The timeout counter clears on every state entry.
- src_req dropping mid-frame: no effect until the frame ends or the timeout fires.
- A requester asserting src_req during IFG waits; arbitration happens only in IDLE.
- Single requester: re-granted after each IFG.
- reset_n low mid-frame: everything returns to reset values immediately, tx_strobe = 0.
- A grant on a source with zero src_valid times out, which is legal.

Optional Feature:
- TX_SCHED_PRIO_EN defined: fixed priority, lowest index wins; the pointer is unused.
- TX_SCHED_PRIO_EN undefined: round-robin as above.
- IFG, abort and timeout behaviour are identical in both modes.

Decomposition:
- Package tx_pkg holds:
  - state enum;
  - word field constants: EOP_BIT = 15, VALID_BIT = 14, BYTE_MSB = 7;
  - ABORT_CNT_W = 8.
- One sub-module, tx_rr_arb: combinational round-robin / fixed-priority pick, taking req and pointer and producing a one-hot winner.

Test Plan:
- Single frame from src0 with words 0x4011, 0x4022, 0xC033, tx_request always 1:
  - one tx_go;
  - three strobes, each 1 cycle high with at least 2 cycles low;
  - tx_word sequence matches the input;
  - grant drops exactly IFG_CYCLES cycles after the last LOW.
- src0 and src1 requesting continuously, 3 frames each: grants alternate 0, 1, 0, 1, 0, 1. With TX_SCHED_PRIO_EN: src0 is granted every time while its request is held.
- tx_request held 0 after tx_go: abort after TIMEOUT_CYCLES; abort_cnt = 1; src_pop pulses until the eop word; then IFG, then IDLE.
- tx_underrun pulse in the middle of a 5-word frame: the remaining words are popped without strobes; abort_cnt increments; the next frame proceeds normally.
- reset_n asserted during STROBE: tx_strobe, grant and busy go to 0 asynchronously. After release, a new request gets tx_go again.
- abort_cnt saturation: 260 timed-out frames → abort_cnt = 255.
